// File: rtl/pipe_addn.sv
// pipe_addn: sliding-window sum of the last N float samples through a pipelined adder tree
module float_add #(
  parameter int LAT = 7
) (
  input  logic        clock,
  input  logic        aclr,
  input  logic        clk_en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);
  logic [31:0] x, y, r;
  logic [7:0] ex, ey, d;
  logic [26:0] mx, my, myy, n;
  logic [27:0] s;
  logic [9:0] e;
  logic [4:0] lz, sa;
  logic [24:0] rm;
  logic sub, up;
  logic [31:0] pipe [LAT];
  // align, add/subtract, normalise and round-to-nearest-even; x always has the larger magnitude
  always_comb begin
    x = (a[30:0] >= b[30:0]) ? a : b;
    y = (a[30:0] >= b[30:0]) ? b : a;
    ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    mx = {|x[30:23], x[22:0], 3'b000};
    my = {|y[30:23], y[22:0], 3'b000};
    d = ex - ey;
    myy = (d > 8'd26) ? {26'd0, |my} : ((my >> d) | {26'd0, |(my & ((27'd1 << d) - 27'd1))});
    sub = x[31] ^ y[31];
    s = sub ? {1'b0, mx} - {1'b0, myy} : {1'b0, mx} + {1'b0, myy};
    lz = 5'd27;
    for (int i = 0; i < 27; i++) if (s[i]) lz = 5'(26 - i);
    e = {2'b00, ex};
    n = s[26:0];
    sa = 5'd0;
    if (s[27]) begin
      n = s[27:1] | {26'd0, s[0]};
      e = e + 10'd1;
    end else begin
      sa = ({5'd0, lz} < e - 10'd1) ? lz : 5'(e - 10'd1);
      n = s[26:0] << sa;
      e = e - {5'd0, sa};
    end
    up = n[2] & (|n[1:0] | n[3]);
    rm = {1'b0, n[26:3]} + {24'd0, up};
    if (rm[24]) begin
      rm = {1'b0, rm[24:1]};
      e = e + 10'd1;
    end
    r = {x[31], (rm[23] ? e[7:0] : 8'd0), rm[22:0]};
    if (e >= 10'd255) r = {x[31], 8'hFF, 23'd0};
    if (s == 28'd0) r = {x[31] & y[31], 31'd0};
    if (x[30:23] == 8'hFF) r = (x[22:0] != 23'd0 || (y[30:23] == 8'hFF && sub)) ? 32'h7FC00000 : x;
  end
  // LAT-deep result pipeline; the adder's whole latency lives here
  always_ff @(posedge clock or posedge aclr)
    if (aclr) for (int i = 0; i < LAT; i++) pipe[i] <= 32'h0;
    else if (clk_en) begin
      pipe[0] <= r;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  assign result = pipe[LAT-1];
endmodule

module pipe_addn #(
  parameter int N        = 3,
  parameter int FADD_LAT = 7,
  parameter int PARTIAL  = 0
) (
  input  logic                     clock,
  input  logic                     aclr_n,
  input  logic                     clk_en,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic [31:0]              in,
  output logic                     out_valid,
  output logic [31:0]              result,
  output logic [$clog2(N+1)-1:0]   fill
);
  localparam int D  = $clog2(N);
  localparam int TL = D * FADD_LAT;
  localparam int FW = $clog2(N + 1);
  function automatic int cnt(int l);
    return (N + (1 << l) - 1) >> l;
  endfunction
  logic [31:0] win [N];
  logic [FW-1:0] fill_next;
  logic tok_in;
  logic [TL:0] tok;
  // fill after this edge; a clear restarts the count from the sample loaded alongside it
  always_comb begin
    fill_next = clear ? FW'(in_valid) : (!in_valid || fill == FW'(N)) ? fill : fill + 1'b1;
    tok_in = in_valid & (PARTIAL != 0 || fill_next == FW'(N));
  end
  // sample window shift register; clear empties it but still captures a coincident sample
  always_ff @(posedge clock or negedge aclr_n)
    if (!aclr_n) for (int i = 0; i < N; i++) win[i] <= 32'h0;
    else if (clk_en) begin
      if (clear) begin
        for (int i = 0; i < N; i++) win[i] <= 32'h0;
        if (in_valid) win[0] <= in;
      end else if (in_valid) begin
        win[0] <= in;
        for (int i = 1; i < N; i++) win[i] <= win[i-1];
      end
    end
  // level l holds ceil(N/2^l) nodes; an unpaired node rides a delay line matching one adder
  for (genvar l = 0; l <= D; l++) begin : lvl
    logic [31:0] v [N];
    for (genvar j = 0; j < N; j++) begin : nd
      if (l == 0) begin : leaf
        assign v[j] = win[j];
      end else if (2*j + 1 < cnt(l-1)) begin : add
        float_add #(.LAT(FADD_LAT)) u_add (
          .clock  (clock),
          .aclr   (~aclr_n),
          .clk_en (clk_en),
          .a      (lvl[l-1].v[2*j]),
          .b      (lvl[l-1].v[2*j+1]),
          .result (v[j])
        );
      end else if (2*j < cnt(l-1)) begin : byp
        logic [31:0] dl [FADD_LAT];
        // bypass delay keeps the odd operand aligned with its paired neighbours
        always_ff @(posedge clock or negedge aclr_n)
          if (!aclr_n) for (int i = 0; i < FADD_LAT; i++) dl[i] <= 32'h0;
          else if (clk_en) begin
            dl[0] <= lvl[l-1].v[2*j];
            for (int i = 1; i < FADD_LAT; i++) dl[i] <= dl[i-1];
          end
        assign v[j] = dl[FADD_LAT-1];
      end else begin : nil
        assign v[j] = 32'h0;
      end
    end
  end
  // fill count, valid tokens travelling alongside the tree, and the output register
  always_ff @(posedge clock or negedge aclr_n)
    if (!aclr_n) begin
      fill <= '0;
      tok <= '0;
      out_valid <= 1'b0;
      result <= 32'h0;
    end else if (clk_en) begin
      fill <= fill_next;
      tok <= clear ? {{TL{1'b0}}, tok_in} : {tok[TL-1:0], tok_in};
      out_valid <= !clear && tok[TL];
      result <= lvl[D].v[0];
    end
endmodule

// File: tb/tb_pipe_addn.sv
// tb_pipe_addn: directed checks of window sums, latency, clear, freeze and reset
module tb_pipe_addn;
  logic clock, aclr_n, clk_en, clear, in_valid;
  logic [31:0] din;
  logic ov3, ov3p, ov5, ov16;
  logic [31:0] r3, r3p, r5, r16;
  logic [1:0] f3, f3p;
  logic [2:0] f5;
  logic [4:0] f16;
  int total, bad, edges;
  logic last_en;
  localparam logic [31:0] F1 = 32'h3F800000, F2 = 32'h40000000, F3 = 32'h40400000,
                          F4 = 32'h40800000, F5 = 32'h40A00000, F6 = 32'h40C00000;

  pipe_addn #(.N(3), .FADD_LAT(7), .PARTIAL(0)) u3 (.clock(clock), .aclr_n(aclr_n), .clk_en(clk_en),
    .clear(clear), .in_valid(in_valid), .in(din), .out_valid(ov3), .result(r3), .fill(f3));
  pipe_addn #(.N(3), .FADD_LAT(7), .PARTIAL(1)) u3p (.clock(clock), .aclr_n(aclr_n), .clk_en(clk_en),
    .clear(clear), .in_valid(in_valid), .in(din), .out_valid(ov3p), .result(r3p), .fill(f3p));
  pipe_addn #(.N(5), .FADD_LAT(7), .PARTIAL(0)) u5 (.clock(clock), .aclr_n(aclr_n), .clk_en(clk_en),
    .clear(clear), .in_valid(in_valid), .in(din), .out_valid(ov5), .result(r5), .fill(f5));
  pipe_addn #(.N(16), .FADD_LAT(7), .PARTIAL(0)) u16 (.clock(clock), .aclr_n(aclr_n), .clk_en(clk_en),
    .clear(clear), .in_valid(in_valid), .in(din), .out_valid(ov16), .result(r16), .fill(f16));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    last_en = clk_en;
    @(posedge clock);
    #1;
    if (last_en) edges++;
  endtask

  task automatic feed(input logic [31:0] x);
    in_valid = 1'b1;
    din = x;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic rst();
    aclr_n = 1'b0; in_valid = 1'b0; clear = 1'b0; clk_en = 1'b1; din = 32'h0;
    tick();
    tick();
    aclr_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] e2 [4];
    logic [31:0] gv [8];
    int go [8];
    int n, a5, hits, hitp;
    logic froze;
    e2 = '{F1, F3, F6, 32'h41100000};
    total = 0; bad = 0; edges = 0;
    // T1/T2: 1,2,3,4 back-to-back into N=3, full-window and partial-sum variants
    rst();
    chk("rst_ov", 32'(ov3), 0);
    chk("rst_res", r3, 0);
    chk("rst_fill", 32'(f3), 0);
    feed(F1); feed(F2); feed(F3); feed(F4);
    chk("t1_fill", 32'(f3), 3);
    chk("t2_fill", 32'(f3p), 3);
    for (int i = 2; i <= 17; i++) begin
      tick();
      chk($sformatf("t1_ov_%0d", i), 32'(ov3), 32'(i == 15 || i == 16));
      if (i == 15) chk("t1_sum6", r3, 32'h40C00000);
      if (i == 16) chk("t1_sum9", r3, 32'h41100000);
      chk($sformatf("t2_ov_%0d", i), 32'(ov3p), 32'(i >= 13 && i <= 16));
      if (i >= 13 && i <= 16) chk($sformatf("t2_sum_%0d", i), r3p, e2[i-13]);
    end
    // T3: N=5 with input gaps and a 5-cycle clk_en freeze while 15.0 is on the output
    rst();
    feed(F1); feed(F2); tick(); tick(); feed(F3); tick(); feed(F4); tick(); tick(); tick();
    feed(F5); a5 = edges; feed(F6);
    n = 0; froze = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (last_en && ov5 && n < 8) begin go[n] = edges - a5; gv[n] = r5; n++; end
      if (edges == a5 + 22 && !froze) begin
        froze = 1'b1;
        clk_en = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("t3_frz_ov", 32'(ov5), 1);
        chk("t3_frz_res", r5, 32'h41700000);
        chk("t3_frz_edges", edges, a5 + 22);
        clk_en = 1'b1;
      end
    end
    chk("t3_count", n, 2);
    chk("t3_lat0", go[0], 22);
    chk("t3_sum15", gv[0], 32'h41700000);
    chk("t3_lat1", go[1], 23);
    chk("t3_sum20", gv[1], 32'h41A00000);
    chk("t3_fill", 32'(f5), 5);
    // T4: clear with a coincident 5.0 while 6.0 is in flight
    rst();
    feed(F1); feed(F2); feed(F3);
    clear = 1'b1; feed(F5); clear = 1'b0;
    chk("t4_fill1", 32'(f3), 1);
    hits = 32'(ov3); hitp = 32'(ov3p);
    feed(F1); hits += 32'(ov3); hitp += 32'(ov3p);
    feed(F1); hits += 32'(ov3); hitp += 32'(ov3p);
    for (int i = 4; i <= 18; i++) begin
      tick();
      if (i < 16) hitp += 32'(ov3p);
      if (i == 16) begin chk("t4p_ov", 32'(ov3p), 1); chk("t4p_sum5", r3p, F5); end
      if (i < 18) hits += 32'(ov3);
      else begin chk("t4_ov", 32'(ov3), 1); chk("t4_sum7", r3, 32'h40E00000); end
    end
    chk("t4_stale", hits, 0);
    chk("t4p_stale", hitp, 0);
    // T5: async reset while a window sum is on the output and another is in flight
    rst();
    feed(F1); feed(F2); feed(F3); feed(F4);
    repeat (14) tick();
    chk("t5_pre_ov", 32'(ov3), 1);
    #2 aclr_n = 1'b0;
    #1;
    chk("t5_ov0", 32'(ov3), 0);
    chk("t5_res0", r3, 0);
    chk("t5_fill0", 32'(f3), 0);
    #1 aclr_n = 1'b1;
    feed(F1); feed(F2); feed(F3);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("t5_ov_%0d", i), 32'(ov3), 32'(i == 15));
      if (i == 15) chk("t5_sum6", r3, 32'h40C00000);
    end
    // T6: N=16, sixteen ones then two more; fill saturates, 16.0 after 29 edges
    rst();
    for (int i = 0; i < 16; i++) feed(F1);
    chk("t6_fill16", 32'(f16), 16);
    feed(F1); feed(F1);
    chk("t6_fill_sat", 32'(f16), 16);
    for (int i = 3; i <= 29; i++) begin
      tick();
      if (i >= 28) chk($sformatf("t6_ov_%0d", i), 32'(ov16), 32'(i == 29));
    end
    chk("t6_sum16", r16, 32'h41800000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
